// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
//
// Receive-side checker for a divided clock generated from clk. The divided
// clock is (optionally) synchronized, edge-detected, and its high time, low
// time and period are measured in clk cycles. Each completed period is compared
// with the expected even divide ratio; consecutive good periods assert
// `locked`, a bad period pulses `mismatch`, and a divided clock that stops
// toggling for TIMEOUT cycles raises `lost`.
//
// Ports:
//   clk        in   monitor clock (the divider's source clock)
//   rst        in   asynchronous active-high reset
//   clk_in     in   divided clock under test
//   meas_valid out  one-cycle pulse: period/high_time/low_time just updated
//   period     out  last complete period, clk cycles (saturating)
//   high_time  out  high portion of the last period
//   low_time   out  low portion of the last period
//   locked     out  LOCK_CNT consecutive matching periods seen
//   mismatch   out  one-cycle pulse with meas_valid when the period is wrong
//   lost       out  level: clk_in has not changed for TIMEOUT cycles
// -----------------------------------------------------------------------------
module clk_div_monitor #(
    parameter int EXP_DIV     = 8,
    parameter int CNT_W       = 8,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             locked,
    output logic             mismatch,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] EXP_PERIOD = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] EXP_HIGH   = CNT_W'(EXP_DIV / 2);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_N     = 4'(LOCK_CNT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. With zero stages clk_in is taken as already
    // synchronous to clk and used directly.
    // -------------------------------------------------------------------------
    logic s;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s = clk_in;
        end else begin : g_sync
            // chain[0] is the raw input, chain[SYNC_STAGES] the synchronized one
            logic [SYNC_STAGES:0] chain;
            assign chain[0] = clk_in;

            genvar gi;
            for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                logic stage_reg;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg <= 1'b0;
                    end else begin
                        stage_reg <= chain[gi];
                    end
                end
                assign chain[gi+1] = stage_reg;
            end

            assign s = chain[SYNC_STAGES];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_reg,      state_next;
    logic             s_d_reg;
    logic [CNT_W-1:0] hi_cnt_reg,     hi_cnt_next;
    logic [CNT_W-1:0] lo_cnt_reg,     lo_cnt_next;
    logic [CNT_W-1:0] run_cnt_reg,    run_cnt_next;
    logic [CNT_W-1:0] period_reg,     period_next;
    logic [CNT_W-1:0] high_time_reg,  high_time_next;
    logic [CNT_W-1:0] low_time_reg,   low_time_next;
    logic [3:0]       match_cnt_reg,  match_cnt_next;
    logic             meas_valid_reg, meas_valid_next;
    logic             mismatch_reg,   mismatch_next;
    logic             locked_reg,     locked_next;
    logic             lost_reg,       lost_next;

    logic             rise;
    logic             fall;
    logic [CNT_W:0]   meas_sum;
    logic [CNT_W-1:0] meas_period;
    logic             meas_match;

    assign rise = s & ~s_d_reg;
    assign fall = ~s & s_d_reg;

    // Period of the measurement closing on this rise, saturated to CNT_W bits.
    assign meas_sum    = {1'b0, hi_cnt_reg} + {1'b0, lo_cnt_reg};
    assign meas_period = meas_sum[CNT_W] ? CNT_MAX : meas_sum[CNT_W-1:0];
    assign meas_match  = (meas_period == EXP_PERIOD) && (hi_cnt_reg == EXP_HIGH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            s_d_reg        <= 1'b0;
            hi_cnt_reg     <= '0;
            lo_cnt_reg     <= '0;
            run_cnt_reg    <= '0;
            period_reg     <= '0;
            high_time_reg  <= '0;
            low_time_reg   <= '0;
            match_cnt_reg  <= '0;
            meas_valid_reg <= 1'b0;
            mismatch_reg   <= 1'b0;
            locked_reg     <= 1'b0;
            lost_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            s_d_reg        <= s;
            hi_cnt_reg     <= hi_cnt_next;
            lo_cnt_reg     <= lo_cnt_next;
            run_cnt_reg    <= run_cnt_next;
            period_reg     <= period_next;
            high_time_reg  <= high_time_next;
            low_time_reg   <= low_time_next;
            match_cnt_reg  <= match_cnt_next;
            meas_valid_reg <= meas_valid_next;
            mismatch_reg   <= mismatch_next;
            locked_reg     <= locked_next;
            lost_reg       <= lost_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        hi_cnt_next     = hi_cnt_reg;
        lo_cnt_next     = lo_cnt_reg;
        run_cnt_next    = run_cnt_reg;
        period_next     = period_reg;
        high_time_next  = high_time_reg;
        low_time_next   = low_time_reg;
        match_cnt_next  = match_cnt_reg;
        meas_valid_next = 1'b0;
        mismatch_next   = 1'b0;
        locked_next     = locked_reg;
        lost_next       = lost_reg;

        // Activity counter: cleared by either edge, parks at TIMEOUT so it
        // can never wrap back into a false "alive" reading.
        if (rise || fall) begin
            run_cnt_next = '0;
        end else if (run_cnt_reg != TIMEOUT_C) begin
            run_cnt_next = run_cnt_reg + 1'b1;
        end

        if (rise) begin
            lost_next = 1'b0;
        end

        unique case (state_reg)
            IDLE: begin
                // Anything seen before the first rise is a partial period.
                if (rise) begin
                    hi_cnt_next = CNT_W'(1);
                    lo_cnt_next = '0;
                    state_next  = RUN;
                end
            end

            RUN: begin
                if (rise) begin
                    period_next     = meas_period;
                    high_time_next  = hi_cnt_reg;
                    low_time_next   = lo_cnt_reg;
                    meas_valid_next = 1'b1;
                    if (meas_match) begin
                        if (match_cnt_reg != LOCK_N) begin
                            match_cnt_next = match_cnt_reg + 4'd1;
                        end
                        if (match_cnt_next == LOCK_N) begin
                            locked_next = 1'b1;
                        end
                    end else begin
                        match_cnt_next = '0;
                        mismatch_next  = 1'b1;
                        locked_next    = 1'b0;
                    end
                    // The rise cycle itself is the first high cycle.
                    hi_cnt_next = CNT_W'(1);
                    lo_cnt_next = '0;
                end else if (s) begin
                    hi_cnt_next = (hi_cnt_reg == CNT_MAX) ? CNT_MAX : hi_cnt_reg + 1'b1;
                end else begin
                    lo_cnt_next = (lo_cnt_reg == CNT_MAX) ? CNT_MAX : lo_cnt_reg + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        // Stopped clock. An edge in this cycle forces run_cnt_next to zero,
        // so an edge coinciding with the timeout wins and is measured.
        if (run_cnt_next == TIMEOUT_C) begin
            lost_next      = 1'b1;
            locked_next    = 1'b0;
            match_cnt_next = '0;
            state_next     = IDLE;
        end
    end

    assign meas_valid = meas_valid_reg;
    assign period     = period_reg;
    assign high_time  = high_time_reg;
    assign low_time   = low_time_reg;
    assign locked     = locked_reg;
    assign mismatch   = mismatch_reg;
    assign lost       = lost_reg;

endmodule
